// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter
// -------------
// Shares the single 64-bit sideband serializer between the SB pattern
// generator and the SB message encoder. Packets are granted atomically with
// round-robin fairness. A programmable idle gap follows every packet, and a
// watchdog aborts any beat the serializer fails to complete in time.
//
// Parameters
//   GAP_CYCLES   idle cycles forced between consecutive packets (0 allowed)
//   SER_TIMEOUT  max cycles a beat may wait for i_ser_done (>= 2)
//
// Ports
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_pattern_valid/i_pattern            pattern beat request and payload
//   o_pattern_ack                        pulse: pattern beat serialized
//   i_msg_valid/i_msg_hdr/i_msg_has_data/i_msg_data
//                                        message packet request and payload
//   o_msg_ack                            pulse: whole message serialized
//   o_ser_data/o_ser_valid/i_ser_done    serializer beat handshake
//   o_busy                               high whenever not IDLE
//   o_ser_timeout                        pulse: beat aborted by the watchdog
module sb_tx_arbiter #(
    parameter int GAP_CYCLES  = 4,
    parameter int SER_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pattern_valid,
    input  logic [63:0] i_pattern,
    output logic        o_pattern_ack,
    input  logic        i_msg_valid,
    input  logic [63:0] i_msg_hdr,
    input  logic        i_msg_has_data,
    input  logic [63:0] i_msg_data,
    output logic        o_msg_ack,
    output logic [63:0] o_ser_data,
    output logic        o_ser_valid,
    input  logic        i_ser_done,
    output logic        o_busy,
    output logic        o_ser_timeout
);

    // One extra count of headroom so the counter can step past the expiry
    // value on the aborting edge without wrapping.
    localparam int WD_W  = $clog2(SER_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(SER_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_PAT,
        ST_SEND_HDR,
        ST_SEND_DATA,
        ST_GAP
    } state_t;

    // Where a finished or aborted packet goes: with no gap, straight to IDLE.
    localparam state_t ST_AFTER_PKT = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t      state_reg, state_next;
    logic        last_grant_msg_reg, last_grant_msg_next;
    logic [WD_W-1:0]  wd_cnt_reg, wd_cnt_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic        has_data_reg, has_data_next;
    logic [63:0] data_reg, data_next;
    logic [63:0] ser_data_reg, ser_data_next;
    logic        ser_valid_reg, ser_valid_next;
    logic        pattern_ack_reg, pattern_ack_next;
    logic        msg_ack_reg, msg_ack_next;
    logic        timeout_reg, timeout_next;
    logic        busy_reg, busy_next;

    logic pat_elig;
    logic msg_elig;
    logic beat_done;
    logic wd_expire;

    // A requester whose ack is on the wire this cycle has not yet had a
    // chance to drop valid, so its request is stale and must not be granted.
    assign pat_elig  = i_pattern_valid && !pattern_ack_reg;
    assign msg_elig  = i_msg_valid && !msg_ack_reg;

    // Done outside a beat is ignored; done in the expiry cycle wins.
    assign beat_done = ser_valid_reg && i_ser_done;
    assign wd_expire = ser_valid_reg && !i_ser_done && (wd_cnt_reg == WD_LAST);

    always_comb begin
        state_next          = state_reg;
        last_grant_msg_next = last_grant_msg_reg;
        has_data_next       = has_data_reg;
        data_next           = data_reg;
        ser_data_next       = ser_data_reg;
        pattern_ack_next    = 1'b0;
        msg_ack_next        = 1'b0;
        timeout_next        = 1'b0;
        gap_cnt_next        = '0;
        // Counts valid cycles of the current beat; any done or idle clears it.
        wd_cnt_next         = (ser_valid_reg && !i_ser_done) ? wd_cnt_reg + WD_W'(1) : '0;

        case (state_reg)
            ST_IDLE: begin
                // Message wins a tie unless it was the last one granted.
                if (msg_elig && (!pat_elig || !last_grant_msg_reg)) begin
                    state_next          = ST_SEND_HDR;
                    ser_data_next       = i_msg_hdr;
                    has_data_next       = i_msg_has_data;
                    data_next           = i_msg_data;
                    last_grant_msg_next = 1'b1;
                    wd_cnt_next         = '0;
                end else if (pat_elig) begin
                    state_next          = ST_SEND_PAT;
                    ser_data_next       = i_pattern;
                    last_grant_msg_next = 1'b0;
                    wd_cnt_next         = '0;
                end
            end
            ST_SEND_PAT: begin
                if (beat_done) begin
                    state_next       = ST_AFTER_PKT;
                    pattern_ack_next = 1'b1;
                end else if (wd_expire) begin
                    state_next   = ST_AFTER_PKT;
                    timeout_next = 1'b1;
                end
            end
            ST_SEND_HDR: begin
                if (beat_done) begin
                    if (has_data_reg) begin
                        // Data beat follows with valid held high throughout.
                        state_next    = ST_SEND_DATA;
                        ser_data_next = data_reg;
                    end else begin
                        state_next   = ST_AFTER_PKT;
                        msg_ack_next = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_next   = ST_AFTER_PKT;
                    timeout_next = 1'b1;
                end
            end
            ST_SEND_DATA: begin
                if (beat_done) begin
                    state_next   = ST_AFTER_PKT;
                    msg_ack_next = 1'b1;
                end else if (wd_expire) begin
                    state_next   = ST_AFTER_PKT;
                    timeout_next = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        ser_valid_next = (state_next == ST_SEND_PAT) || (state_next == ST_SEND_HDR) ||
                         (state_next == ST_SEND_DATA);
        busy_next      = (state_next != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg          <= ST_IDLE;
            last_grant_msg_reg <= 1'b0;
            wd_cnt_reg         <= '0;
            gap_cnt_reg        <= '0;
            has_data_reg       <= 1'b0;
            data_reg           <= '0;
            ser_data_reg       <= '0;
            ser_valid_reg      <= 1'b0;
            pattern_ack_reg    <= 1'b0;
            msg_ack_reg        <= 1'b0;
            timeout_reg        <= 1'b0;
            busy_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            last_grant_msg_reg <= last_grant_msg_next;
            wd_cnt_reg         <= wd_cnt_next;
            gap_cnt_reg        <= gap_cnt_next;
            has_data_reg       <= has_data_next;
            data_reg           <= data_next;
            ser_data_reg       <= ser_data_next;
            ser_valid_reg      <= ser_valid_next;
            pattern_ack_reg    <= pattern_ack_next;
            msg_ack_reg        <= msg_ack_next;
            timeout_reg        <= timeout_next;
            busy_reg           <= busy_next;
        end
    end

    assign o_ser_data    = ser_data_reg;
    assign o_ser_valid   = ser_valid_reg;
    assign o_pattern_ack = pattern_ack_reg;
    assign o_msg_ack     = msg_ack_reg;
    assign o_ser_timeout = timeout_reg;
    assign o_busy        = busy_reg;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for sb_tx_arbiter. Two always-pending requesters feed randomized
// packets; a serializer model completes beats after random delays or lets the
// watchdog fire. The expected stream of beats, acks and timeouts is planned up
// front from the arbitration rules and checked by a negedge monitor.
module tb_sb_tx_arbiter;
    localparam int GAP   = 3;
    localparam int TMO   = 16;
    localparam int N_PAT = 12;
    localparam int N_MSG = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hdr;
        logic        has_data;
        logic [63:0] data;
    } msg_t;

    typedef enum int {EV_BEAT, EV_ACK_PAT, EV_ACK_MSG, EV_TIMEOUT} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [63:0] data;
    } ev_t;

    // Automatic (randomized) and manual (directed) drive, muxed onto the DUT.
    logic auto_en = 1'b1;
    logic mon_en  = 1'b0;
    logic a_pattern_valid = 1'b0, a_msg_valid = 1'b0, a_msg_has_data = 1'b0, a_ser_done = 1'b0;
    logic [63:0] a_pattern = '0, a_msg_hdr = '0, a_msg_data = '0;
    logic m_pattern_valid = 1'b0, m_msg_valid = 1'b0, m_msg_has_data = 1'b0, m_ser_done = 1'b0;
    logic [63:0] m_pattern = '0, m_msg_hdr = '0, m_msg_data = '0;

    logic        pattern_valid, msg_valid, msg_has_data, ser_done;
    logic [63:0] pattern, msg_hdr, msg_data;
    logic        pattern_ack, msg_ack, ser_valid, busy, ser_timeout;
    logic [63:0] ser_data;

    assign pattern_valid = auto_en ? a_pattern_valid : m_pattern_valid;
    assign pattern       = auto_en ? a_pattern       : m_pattern;
    assign msg_valid     = auto_en ? a_msg_valid     : m_msg_valid;
    assign msg_hdr       = auto_en ? a_msg_hdr       : m_msg_hdr;
    assign msg_has_data  = auto_en ? a_msg_has_data  : m_msg_has_data;
    assign msg_data      = auto_en ? a_msg_data      : m_msg_data;
    assign ser_done      = auto_en ? a_ser_done      : m_ser_done;

    sb_tx_arbiter #(.GAP_CYCLES(GAP), .SER_TIMEOUT(TMO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pattern_valid(pattern_valid),
        .i_pattern      (pattern),
        .o_pattern_ack  (pattern_ack),
        .i_msg_valid    (msg_valid),
        .i_msg_hdr      (msg_hdr),
        .i_msg_has_data (msg_has_data),
        .i_msg_data     (msg_data),
        .o_msg_ack      (msg_ack),
        .o_ser_data     (ser_data),
        .o_ser_valid    (ser_valid),
        .i_ser_done     (ser_done),
        .o_busy         (busy),
        .o_ser_timeout  (ser_timeout)
    );

    int vectors     = 0;
    int miscompares = 0;

    ev_t         exp_q[$];
    int          outcome_q[$];   // per beat: valid cycles before done, -1 = withhold
    int          forced_q[$];
    logic [63:0] a_pat_q[$];
    msg_t        a_msg_q[$];
    logic [63:0] mdl_pat_q[$];
    msg_t        mdl_msg_q[$];

    function automatic string kind_str(input ev_kind_t k);
        case (k)
            EV_BEAT:    return "beat";
            EV_ACK_PAT: return "pattern_ack";
            EV_ACK_MSG: return "msg_ack";
            default:    return "timeout";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    function automatic void push_ev(input ev_kind_t k, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic int pick_outcome();
        int r;
        if (forced_q.size() > 0) return forced_q.pop_front();
        r = int'($urandom_range(0, 9));
        if (r == 0) return -1;
        if (r == 1) return TMO - 1;   // done lands on the watchdog expiry cycle
        return int'($urandom_range(0, 4));
    endfunction

    // One serializer beat: expect it on the wire, then either completion or abort.
    function automatic bit plan_beat(input logic [63:0] d);
        int oc;
        oc = pick_outcome();
        outcome_q.push_back(oc);
        push_ev(EV_BEAT, d);
        if (oc < 0) push_ev(EV_TIMEOUT, 64'd0);
        return oc >= 0;
    endfunction

    // Reference model: both requesters keep a packet pending until their
    // queue runs dry; ties alternate, starting with the message.
    task automatic build_plan();
        bit last_msg = 1'b0;
        bit take_msg;
        bit ok;
        msg_t m;
        while (mdl_pat_q.size() > 0 || mdl_msg_q.size() > 0) begin
            if (mdl_pat_q.size() > 0 && mdl_msg_q.size() > 0) take_msg = !last_msg;
            else take_msg = (mdl_msg_q.size() > 0);
            last_msg = take_msg;
            if (!take_msg) begin
                ok = plan_beat(mdl_pat_q[0]);
                if (ok) begin
                    push_ev(EV_ACK_PAT, 64'd0);
                    void'(mdl_pat_q.pop_front());
                end
            end else begin
                m  = mdl_msg_q[0];
                ok = plan_beat(m.hdr);
                if (ok && m.has_data) ok = plan_beat(m.data);
                if (ok) begin
                    push_ev(EV_ACK_MSG, 64'd0);
                    void'(mdl_msg_q.pop_front());
                end
            end
        end
    endtask

    // Requester models: hold valid until ack; payload is garbage while the
    // arbiter is busy so only the captured copy can reach the serializer.
    always @(posedge clk) begin
        #1;
        if (auto_en) begin
            if (pattern_ack && a_pat_q.size() > 0) void'(a_pat_q.pop_front());
            if (msg_ack && a_msg_q.size() > 0) void'(a_msg_q.pop_front());
            a_pattern_valid = (a_pat_q.size() > 0);
            a_msg_valid     = (a_msg_q.size() > 0);
            if (busy) begin
                a_pattern      = {$urandom, $urandom};
                a_msg_hdr      = {$urandom, $urandom};
                a_msg_data     = {$urandom, $urandom};
                a_msg_has_data = $urandom_range(0, 1) == 1;
            end else begin
                a_pattern      = a_pattern_valid ? a_pat_q[0] : 64'd0;
                a_msg_hdr      = a_msg_valid ? a_msg_q[0].hdr : 64'd0;
                a_msg_data     = a_msg_valid ? a_msg_q[0].data : 64'd0;
                a_msg_has_data = a_msg_valid ? a_msg_q[0].has_data : 1'b0;
            end
        end
    end

    // Serializer model: completes each beat after its planned delay, and
    // throws stray done pulses while nothing is valid.
    bit in_beat = 1'b0, done_pending = 1'b0;
    int cyc = 0, cur_oc = 0;
    always @(posedge clk) begin
        #1;
        a_ser_done = 1'b0;
        if (!auto_en) begin
            in_beat      = 1'b0;
            done_pending = 1'b0;
        end else begin
            if (done_pending) begin
                in_beat      = 1'b0;
                done_pending = 1'b0;
            end
            if (!ser_valid) begin
                in_beat = 1'b0;
            end else if (!in_beat) begin
                in_beat = 1'b1;
                cyc     = 0;
                cur_oc  = (outcome_q.size() > 0) ? outcome_q.pop_front() : 0;
            end else begin
                cyc++;
            end
            if (in_beat && cur_oc == cyc) begin
                a_ser_done   = 1'b1;
                done_pending = 1'b1;
            end else if (!ser_valid) begin
                a_ser_done = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: turns DUT activity into events and checks them against the plan.
    bit          prev_valid = 1'b0, prev_done = 1'b0, seen_end = 1'b0;
    int          low_run = 0, beat_len = 0;
    logic [63:0] cur_data = '0;

    task automatic check_event(input ev_kind_t k, input logic [63:0] d);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event_order: got %s %h, expected nothing more", kind_str(k), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_BEAT && e.data !== d)) begin
                miscompares++;
                $display("FAIL event_order: got %s %h, expected %s %h",
                         kind_str(k), d, kind_str(e.kind), e.data);
            end
        end
    endtask

    task automatic end_of_packet(input string nm);
        vectors++;
        if (ser_valid || !prev_valid) begin
            miscompares++;
            $display("FAIL %s_timing: got valid=%0b prev_valid=%0b, expected 0 after 1",
                     nm, ser_valid, prev_valid);
        end
        seen_end = 1'b1;
        low_run  = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ser_valid && (!prev_valid || prev_done)) begin
                if (!prev_valid && seen_end) chk("gap_len", 64'(low_run), 64'(GAP + 1));
                seen_end = 1'b0;
                check_event(EV_BEAT, ser_data);
                cur_data = ser_data;
                beat_len = 1;
            end else if (ser_valid) begin
                beat_len++;
                chk("beat_hold", ser_data, cur_data);
            end
            if (pattern_ack) begin
                check_event(EV_ACK_PAT, 64'd0);
                end_of_packet("pattern_ack");
            end
            if (msg_ack) begin
                check_event(EV_ACK_MSG, 64'd0);
                end_of_packet("msg_ack");
            end
            if (ser_timeout) begin
                check_event(EV_TIMEOUT, 64'd0);
                chk("timeout_valid_cycles", 64'(beat_len), 64'(TMO));
                end_of_packet("timeout");
            end
            if (ser_valid) begin
                chk("busy_active", 64'(busy), 64'd1);
            end else if (seen_end) begin
                chk("busy_gap", 64'(busy), 64'(low_run < GAP));
                low_run++;
            end
            prev_valid = ser_valid;
            prev_done  = ser_done;
        end
    end

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !ser_valid; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        msg_t m;
        logic [63:0] p;
        // Spec example first, then random traffic.
        m.hdr = 64'hA5A5_0000_0000_0001; m.has_data = 1'b1; m.data = 64'hDEAD_BEEF_CAFE_F00D;
        a_msg_q.push_back(m);
        mdl_msg_q.push_back(m);
        for (int i = 1; i < N_MSG; i++) begin
            m.hdr      = {$urandom, $urandom};
            m.has_data = $urandom_range(0, 1) == 1;
            m.data     = {$urandom, $urandom};
            a_msg_q.push_back(m);
            mdl_msg_q.push_back(m);
        end
        for (int i = 0; i < N_PAT; i++) begin
            p = {$urandom, $urandom};
            a_pat_q.push_back(p);
            mdl_pat_q.push_back(p);
        end
        // hdr and data complete after 3 cycles, first pattern times out,
        // next header completes exactly on the expiry cycle.
        forced_q.push_back(3);
        forced_q.push_back(3);
        forced_q.push_back(-1);
        forced_q.push_back(TMO - 1);
        build_plan();

        #1;
        chk("reset_ser_valid", 64'(ser_valid), 64'd0);
        chk("reset_ser_data", ser_data, 64'd0);
        chk("reset_pattern_ack", 64'(pattern_ack), 64'd0);
        chk("reset_msg_ack", 64'(msg_ack), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_timeout", 64'(ser_timeout), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int n = 0; n < 20000 && exp_q.size() > 0; n++) @(posedge clk);
        chk("plan_drained", 64'(exp_q.size()), 64'd0);
        repeat (GAP + 3) @(posedge clk);
        #1;
        chk("final_idle_busy", 64'(busy), 64'd0);
        chk("final_idle_valid", 64'(ser_valid), 64'd0);
        chk("outcomes_used", 64'(outcome_q.size()), 64'd0);

        // Directed: reset while the data beat is on the wire.
        mon_en  = 1'b0;
        auto_en = 1'b0;
        m_msg_hdr      = 64'h1111_2222_3333_4444;
        m_msg_data     = 64'h5555_6666_7777_8888;
        m_msg_has_data = 1'b1;
        m_msg_valid    = 1'b1;
        wait_valid(8);
        chk("rst_case_hdr", ser_data, 64'h1111_2222_3333_4444);
        m_ser_done = 1'b1;
        @(posedge clk);
        #1;
        m_ser_done = 1'b0;
        chk("rst_case_data_valid", 64'(ser_valid), 64'd1);
        chk("rst_case_data", ser_data, 64'h5555_6666_7777_8888);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(ser_valid), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        m_msg_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_ack", 64'({pattern_ack, msg_ack, ser_timeout}), 64'd0);
        end

        // After release both request at once: the message must win the tie.
        m_pattern       = 64'h0F0F_1234_5678_9ABC;
        m_pattern_valid = 1'b1;
        m_msg_hdr       = 64'hC0DE_0000_0000_0002;
        m_msg_has_data  = 1'b0;
        m_msg_valid     = 1'b1;
        rst             = 1'b0;
        wait_valid(8);
        chk("tie_after_reset", ser_data, 64'hC0DE_0000_0000_0002);
        m_ser_done = 1'b1;
        @(posedge clk);
        #1;
        m_ser_done = 1'b0;
        chk("tie_msg_ack", 64'(msg_ack), 64'd1);
        chk("tie_no_pattern_ack", 64'(pattern_ack), 64'd0);
        m_msg_valid = 1'b0;
        wait_valid(GAP + 4);
        chk("pattern_after_msg", ser_data, 64'h0F0F_1234_5678_9ABC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/sb_tx_arbiter.md
# sb_tx_arbiter

Sideband transmit scheduler that shares the single 64-bit sideband serializer between two requesters: the sideband pattern generator and the sideband message encoder. It grants the serializer packet-atomically with round-robin fairness and drives the serializer beat handshake. It enforces a programmable idle gap between packets and a watchdog on serializer completion. It sits between the SB pattern generator / message encoder and the SB serializer in the sideband TX path.

## Interface
Parameters:
- GAP_CYCLES, 4, idle i_clk cycles forced between consecutive packets (0 allowed).
- SER_TIMEOUT, 1024, max cycles a beat may wait for i_ser_done before abort (≥2).

Ports:
- i_clk  in  1  sideband clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_pattern_valid  in  1  pattern generator has a 64-bit pattern beat pending.
- i_pattern  in  64  pattern beat.
- o_pattern_ack  out  1  one-cycle pulse: pattern beat fully serialized.
- i_msg_valid  in  1  message encoder has a packet pending.
- i_msg_hdr  in  64  message header beat.
- i_msg_has_data  in  1  packet carries a 64-bit data beat after the header.
- i_msg_data  in  64  message data beat.
- o_msg_ack  out  1  one-cycle pulse: whole message packet serialized.
- o_ser_data  out  64  beat to serializer.
- o_ser_valid  out  1  o_ser_data valid; held until i_ser_done.
- i_ser_done  in  1  serializer finished current beat (single-cycle pulse).
- o_busy  out  1  high in any state other than IDLE.
- o_ser_timeout  out  1  one-cycle pulse: beat aborted by watchdog.

## Operation
- FSM states: IDLE, SEND_PAT, SEND_HDR, SEND_DATA, GAP.
- IDLE: eligible requester = valid high AND its ack not asserted this cycle. This rule blocks re-grant of a stale request.
- Arbitration when both requesters are eligible: grant the one not granted last (last_grant pointer). Single eligible requester: grant it.
- On grant, capture the payload (pattern, or hdr/has_data/data) into internal registers. Update last_grant.
- Grant pattern -> SEND_PAT. Grant message -> SEND_HDR.
- SEND_PAT: drive captured pattern. On i_ser_done -> GAP, pulse o_pattern_ack.
- SEND_HDR: drive captured header. On i_ser_done:
  - has_data=1 -> SEND_DATA; no gap and no valid drop between beats.
  - has_data=0 -> GAP, pulse o_msg_ack.
- SEND_DATA: drive captured data. On i_ser_done -> GAP, pulse o_msg_ack.
- GAP: o_ser_valid low for GAP_CYCLES cycles, then IDLE. With GAP_CYCLES=0, the FSM goes straight to IDLE.
- Watchdog counter, width $clog2(SER_TIMEOUT+1):
  - Clears at each beat start and on each i_ser_done; counts every cycle o_ser_valid is high.
  - On reaching SER_TIMEOUT-1 with no i_ser_done in the same cycle: drop o_ser_valid, pulse o_ser_timeout, go to GAP, no ack.
  - The aborted requester's valid remains pending and re-arbitrates normally. last_grant already points to it, so the other requester wins a tie.
- i_ser_done when o_ser_valid is low: ignored.
- i_ser_done in the same cycle the watchdog expires: done wins; normal completion, no timeout.
- Captured payload is used, so input changes after grant do not affect the packet in flight. Requesters still hold valid until ack.

## Timing
- Reset (async assert): state=IDLE, last_grant=pattern (message wins first tie), counters=0. o_ser_data=0, o_ser_valid=0, o_pattern_ack=0, o_msg_ack=0, o_busy=0, o_ser_timeout=0.
- Reset mid-packet: o_ser_valid drops immediately. No ack and no timeout are issued.
- Grant latency: request eligible in IDLE at edge N -> o_ser_valid=1 with data from cycle N+1 (all outputs registered).
- Beat switch: i_ser_done on header at edge M -> o_ser_data=data at M+1, o_ser_valid continuously high.
- Ack and timeout pulses are asserted the cycle after the completing/expiring edge, for exactly one cycle.
- Packet-to-packet gap: last i_ser_done at edge M -> o_ser_valid low for cycles M+1..M+GAP_CYCLES. Earliest next o_ser_valid is at M+GAP_CYCLES+2 (one IDLE grant cycle).
- o_busy is registered from the state; it is low only in IDLE.

## Test plan
- Single pattern, GAP_CYCLES=4: pattern valid, i_ser_done 3 cycles after o_ser_valid -> o_ser_data=pattern, one o_pattern_ack pulse, 4 idle cycles, back to IDLE with o_busy=0.
- Message with data: hdr=64'hA5A5_0000_0000_0001, data=64'hDEAD_BEEF_CAFE_F00D, has_data=1 -> two beats back-to-back with o_ser_valid never dropping; single o_msg_ack only after the second i_ser_done.
- Contention: both valid from reset, held through 4 packets -> grant order msg, pat, msg, pat. Exactly 4 acks; no stale re-grant with GAP_CYCLES=0.
- Watchdog, SER_TIMEOUT=16: withhold i_ser_done -> o_ser_valid drops after 16 valid cycles, o_ser_timeout pulses once, no ack; the other pending requester is granted next. Also: i_ser_done in the expiry cycle -> ack, no timeout.
- Reset mid-SEND_DATA: assert i_rst -> o_ser_valid=0 asynchronously, no ack. After release, a message request is granted first on a tie.
